// File: rtl/fetch_decode_queue_if.sv
// Fetch-to-decode handshake bundle.
// Fetch side pushes, decode side pops.
interface fetch_decode_queue_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic [N-1:0] inst_in;
  logic [N-1:0] pc_in;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] inst_out;
  logic [N-1:0] pc_out;
  logic         out_ready;

  modport master (
    output in_valid,
    output inst_in,
    output pc_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  inst_out,
    input  pc_out
  );

  modport slave (
    input  in_valid,
    input  inst_in,
    input  pc_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output inst_out,
    output pc_out
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Instruction/PC FIFO between fetch and decode.
// Flush on redirect empties it; count decides full/empty.
module fetch_decode_queue #(
  parameter int             N     = 32,
  parameter int             DEPTH = 4,
  parameter logic [N-1:0]   NOP   = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  fetch_decode_queue_if.slave       bus,
  output logic [$clog2(DEPTH):0]    count,
  output logic [7:0]                flush_drops
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [N-1:0]  inst_mem [DEPTH];
  logic [N-1:0]  pc_mem   [DEPTH];
  logic          push;
  logic          pop;

  assign bus.in_ready  = (count < FULL);
  assign bus.out_valid = (count != '0);
  assign push = bus.in_valid & bus.in_ready & ~flush;
  assign pop  = bus.out_valid & bus.out_ready & ~flush;

  assign bus.inst_out = bus.out_valid ? inst_mem[rd_ptr] : NOP;
  assign bus.pc_out   = bus.out_valid ? pc_mem[rd_ptr] : '0;

  // Pointers and occupancy; flush overrides any push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of flushes that actually dropped entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_drops <= '0;
    end else if (flush && count != '0
                 && flush_drops != 8'hFF) begin
      flush_drops <= flush_drops + 8'd1;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= bus.inst_in;
      pc_mem[wr_ptr]   <= bus.pc_in;
    end
  end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue.
// Directed plan steps followed by random traffic.
module tb_fetch_decode_queue;
  localparam int N = 32;
  localparam int DEPTH = 4;
  localparam logic [N-1:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [N-1:0] inst;
    logic [N-1:0] pc;
  } ent_t;

  logic clk = 0;
  logic rst = 0;
  logic flush = 0;
  logic [$clog2(DEPTH):0] count;
  logic [7:0] flush_drops;

  fetch_decode_queue_if #(.N(N)) bus();

  fetch_decode_queue #(
    .N(N), .DEPTH(DEPTH), .NOP(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus),
    .count(count),
    .flush_drops(flush_drops)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ent_t sb[$];
  int   mcnt  = 0;
  int   mdrops = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Reference model: occupancy, drop counter, accepted pushes.
  always @(posedge clk) begin
    if (rst) begin
      checks++;
      if ($isunknown(bus.in_valid) ||
          $isunknown(bus.out_ready)) begin
        errors++;
        $display("FAIL xcheck: in_valid=%b out_ready=%b",
                 bus.in_valid, bus.out_ready);
      end
      if (flush) begin
        if (mcnt > 0 && mdrops < 255) mdrops++;
        mcnt = 0;
        sb.delete();
      end else begin
        if (bus.in_valid && mcnt < DEPTH) begin
          sb.push_back('{bus.inst_in, bus.pc_in});
          mcnt++;
        end
        if (bus.out_ready && mcnt_prev_nonzero()) mcnt--;
      end
    end
  end

  int pre_cnt = 0;
  function automatic bit mcnt_prev_nonzero();
    return pre_cnt != 0;
  endfunction

  // Snapshot occupancy before each edge so pop uses the old value.
  always @(negedge clk) pre_cnt = mcnt;

  always @(negedge rst) begin
    sb.delete();
    mcnt = 0;
    mdrops = 0;
    pre_cnt = 0;
  end

  // Monitor: compare outputs, pop scoreboard on a real handshake.
  always @(negedge clk) begin
    if (rst) begin
      chk("count", 32'(count), 32'(mcnt));
      chk("in_ready", 32'(bus.in_ready), 32'(mcnt < DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(mcnt != 0));
      chk("flush_drops", 32'(flush_drops), 32'(mdrops));
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL head: got %h expected none",
                   bus.inst_out);
        end else begin
          chk("inst_out", bus.inst_out, sb[0].inst);
          chk("pc_out", bus.pc_out, sb[0].pc);
          if (bus.out_ready && !flush) void'(sb.pop_front());
        end
      end else begin
        chk("inst_nop", bus.inst_out, NOP);
        chk("pc_zero", bus.pc_out, 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [31:0] i,
                       logic [31:0] p, bit r);
    bus.in_valid  = v;
    bus.inst_in   = i;
    bus.pc_in     = p;
    bus.out_ready = r;
  endtask

  initial begin
    drive(0, 0, 0, 0);
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_inst", bus.inst_out, NOP);
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_drops", 32'(flush_drops), 32'h0);
    step();
    rst = 1;

    // fill
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h11 * (i + 1), i, 0);
      step();
      chk("fill_count", 32'(count), i + 1);
    end
    chk("full_in_ready", 32'(bus.in_ready), 32'h0);
    drive(1, 32'h55, 4, 0);
    step();
    chk("refused_count", 32'(count), 32'h4);
    chk("refused_head", bus.inst_out, 32'h11);
    chk("refused_pc", bus.pc_out, 32'h0);

    // drain and wrap
    drive(1, 32'h55, 4, 1);
    step();
    chk("pop_refuse_cnt", 32'(count), 32'h3);
    step();
    chk("repush_cnt", 32'(count), 32'h3);
    chk("repush_head", bus.inst_out, 32'h33);
    drive(0, 0, 0, 1);
    repeat (3) step();
    chk("drained", 32'(count), 32'h0);

    // push+pop at count 1
    drive(1, 32'hAA, 8, 0);
    step();
    drive(1, 32'hBB, 9, 1);
    step();
    chk("pp_count", 32'(count), 32'h1);
    chk("pp_head", bus.inst_out, 32'hBB);
    chk("pp_pc", bus.pc_out, 32'h9);
    drive(0, 0, 0, 1);
    step();

    // flush with pending push
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hC0 + i, 16 + i, 0);
      step();
    end
    drive(1, 32'hCC, 32'h40, 0);
    flush = 1;
    step();
    flush = 0;
    drive(0, 0, 0, 1);
    chk("fl_count", 32'(count), 32'h0);
    chk("fl_valid", 32'(bus.out_valid), 32'h0);
    chk("fl_inst", bus.inst_out, NOP);
    chk("fl_pc", bus.pc_out, 32'h0);
    chk("fl_drops", 32'(flush_drops), 32'h1);
    flush = 1;
    step();
    flush = 0;
    step();
    chk("fl2_drops", 32'(flush_drops), 32'h1);
    chk("fl2_valid", 32'(bus.out_valid), 32'h0);

    // async reset mid-stream
    drive(1, 32'hD0, 32, 0);
    step();
    drive(1, 32'hD1, 33, 0);
    step();
    drive(0, 0, 0, 0);
    #2;
    rst = 0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 32'h0);
    chk("ar_count", 32'(count), 32'h0);
    chk("ar_drops", 32'(flush_drops), 32'h0);
    step();
    rst = 1;
    step();

    // saturation
    for (int i = 0; i < 260; i++) begin
      drive(1, i, i, 0);
      step();
      drive(0, 0, 0, 0);
      flush = 1;
      step();
      flush = 0;
    end
    chk("sat", 32'(flush_drops), 32'd255);
    drive(1, 1, 1, 0);
    step();
    drive(0, 0, 0, 0);
    flush = 1;
    step();
    flush = 0;
    chk("sat_hold", 32'(flush_drops), 32'd255);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom(),
            $urandom(), $urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      step();
    end
    drive(0, 0, 0, 0);
    flush = 0;
    step();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
